// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - parametrised synchronous clock divider bank with lock and reconfiguration
//
// Purpose: derives NUM_CLKS divided square-wave clocks and matching one-cycle
// clock-enable strobes from refclk. Each channel has its own divide ratio and
// phase offset. After a settling delay of LOCK_DELAY cycles the block locks and
// all channels start aligned to the same reference cycle T0. A valid/ready port
// reprograms one channel at a time and forces a relock of all channels.
//
// Ports:
//   refclk     in   sole clock
//   rst        in   synchronous active-high reset
//   outclk     out  [NUM_CLKS] divided clocks (registered)
//   clk_en     out  [NUM_CLKS] one-cycle strobe coincident with each outclk rising edge
//   locked     out  outputs valid and phase-aligned
//   cfg_valid  in   reconfiguration request
//   cfg_ready  out  request accepted in a cycle where cfg_valid is also high
//   cfg_chan   in   [CH_W] channel to reprogram
//   cfg_div    in   [CNT_W] new divide ratio (>= 2)
//   cfg_phase  in   [CNT_W] new phase offset (< cfg_div)
//   cfg_err    out  one-cycle pulse after an accepted but rejected request
module clk_div_gen #(
   parameter int NUM_CLKS = 2,
   parameter int CNT_W = 16,
   parameter int CH_W = 1,
   parameter logic [NUM_CLKS*CNT_W-1:0] DIV_INIT = {16'd2, 16'd2},
   parameter logic [NUM_CLKS*CNT_W-1:0] PHASE_INIT = {16'd1, 16'd0},
   parameter int LOCK_DELAY = 16
) (
   input  logic                refclk,
   input  logic                rst,
   output logic [NUM_CLKS-1:0] outclk,
   output logic [NUM_CLKS-1:0] clk_en,
   output logic                locked,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_chan,
   input  logic [CNT_W-1:0]    cfg_div,
   input  logic [CNT_W-1:0]    cfg_phase,
   output logic                cfg_err
);

   localparam int DW = $clog2(LOCK_DELAY + 1);

   typedef enum logic {ST_WAIT, ST_LOCKED} state_t;

   state_t state_r, state_n;
   logic [DW-1:0] dly_r;

   logic [CNT_W-1:0] div_r   [NUM_CLKS];
   logic [CNT_W-1:0] phase_r [NUM_CLKS];
   // Per-channel down-counter: cycles remaining until the next rising edge.
   logic [CNT_W-1:0] dc_r    [NUM_CLKS];
   logic [CNT_W-1:0] dc_n    [NUM_CLKS];
   // Set once the channel has produced its first edge since lock.
   logic [NUM_CLKS-1:0] run_r, run_n;
   logic [NUM_CLKS-1:0] out_n, en_n;

   logic xfer, req_ok;

   // cfg_ready depends only on registered state, so there is no path from cfg_valid.
   assign locked    = (state_r == ST_LOCKED);
   assign cfg_ready = (state_r == ST_LOCKED);

   always_comb begin
      state_n = state_r;
      xfer    = cfg_valid && (state_r == ST_LOCKED);
      req_ok  = (cfg_div >= CNT_W'(2)) && (cfg_phase < cfg_div) &&
                (32'(cfg_chan) < NUM_CLKS);
      case (state_r)
         ST_WAIT:   if (dly_r == DW'(LOCK_DELAY - 1)) state_n = ST_LOCKED;
         ST_LOCKED: if (xfer && req_ok) state_n = ST_WAIT;
         default:   state_n = ST_WAIT;
      endcase
   end

   // Next counter/output values. While waiting, every counter is preloaded
   // with its phase so that the cycle entering LOCKED is T0 for all channels.
   // Outputs are produced from the next counter value so they are registered
   // yet line up with the counter in the same cycle.
   always_comb begin
      out_n = '0;
      en_n  = '0;
      run_n = run_r;
      for (int i = 0; i < NUM_CLKS; i++) begin
         dc_n[i] = dc_r[i];
         if (state_r == ST_WAIT) begin
            dc_n[i]  = phase_r[i];
            run_n[i] = (phase_r[i] == '0);
         end else begin
            dc_n[i]  = (dc_r[i] == '0) ? div_r[i] - CNT_W'(1) : dc_r[i] - CNT_W'(1);
            run_n[i] = run_r[i] | (dc_n[i] == '0);
         end
         // High phase k in [0, d/2): counter is 0 or above d - d/2.
         if (state_n == ST_LOCKED && run_n[i]) begin
            en_n[i]  = (dc_n[i] == '0);
            out_n[i] = (dc_n[i] == '0) || (dc_n[i] > div_r[i] - (div_r[i] >> 1));
         end
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_r <= ST_WAIT;
         dly_r   <= '0;
         outclk  <= '0;
         clk_en  <= '0;
         cfg_err <= 1'b0;
         run_r   <= '0;
         for (int i = 0; i < NUM_CLKS; i++) begin
            div_r[i]   <= DIV_INIT[i*CNT_W +: CNT_W];
            phase_r[i] <= PHASE_INIT[i*CNT_W +: CNT_W];
            dc_r[i]    <= '0;
         end
      end else begin
         state_r <= state_n;
         if (state_r == ST_WAIT && state_n == ST_WAIT) begin
            dly_r <= dly_r + DW'(1);
         end else begin
            dly_r <= '0;
         end
         outclk  <= out_n;
         clk_en  <= en_n;
         cfg_err <= xfer && !req_ok;
         run_r   <= run_n;
         for (int i = 0; i < NUM_CLKS; i++) begin
            dc_r[i] <= dc_n[i];
            if (xfer && req_ok && cfg_chan == CH_W'(i)) begin
               div_r[i]   <= cfg_div;
               phase_r[i] <= cfg_phase;
            end
         end
      end
   end

endmodule
